// File: rtl/rf_alu_exec_pkg.sv
// Shared definitions for the execute/write-back sequencer.
// Holds the ALU opcode encoding and the sequencer state encoding (2 bits).
package rf_alu_exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } exec_state_e;

endpackage

// File: rtl/rf_alu_exec_alu.sv
// Purely combinational ALU: y = op(a, b).
// Ports: op (3-bit opcode), a/b (DATA_W operands), y (DATA_W result).
// Arithmetic wraps modulo 2^DATA_W; shifts use only b[4:0].
module rf_alu
    import rf_alu_exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    logic        slt_s;
    logic [4:0]  shamt_s;

    assign slt_s   = ($signed(a) < $signed(b));
    assign shamt_s = b[4:0];

    // Opcode decode to the selected result.
    always_comb begin
        y = {DATA_W{1'b0}};
        case (alu_op_e'(op))
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << shamt_s;
            ALU_SRL: y = a >> shamt_s;
            ALU_SLT: y = {{(DATA_W-1){1'b0}}, slt_s};
            default: y = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/rf_alu_exec.sv
// Execute/write-back sequencer in front of a 32x32 register file.
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_rs1/
// cmd_rs2/cmd_rd command handshake; rf_rs1/rf_rs2/rf_rd/rf_we/rf_indata to the
// regfile, rf_rv1/rf_rv2 combinational read data back; res_valid one-cycle
// result strobe with res_data held until the next result.
// Sequence per command: IDLE -(accept)-> READ -> EXEC -> WB -> IDLE.
module rf_alu_exec
    import rf_alu_exec_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [REG_W-1:0]  cmd_rs1,
    input  logic [REG_W-1:0]  cmd_rs2,
    input  logic [REG_W-1:0]  cmd_rd,
    output logic [REG_W-1:0]  rf_rs1,
    output logic [REG_W-1:0]  rf_rs2,
    output logic [REG_W-1:0]  rf_rd,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_indata,
    input  logic [DATA_W-1:0] rf_rv1,
    input  logic [DATA_W-1:0] rf_rv2,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data
);

    exec_state_e        state_r;
    exec_state_e        state_nxt_s;
    logic [2:0]         op_r;
    logic [REG_W-1:0]   rs1_r;
    logic [REG_W-1:0]   rs2_r;
    logic [REG_W-1:0]   rd_r;
    logic [DATA_W-1:0]  opa_r;
    logic [DATA_W-1:0]  opb_r;
    logic [DATA_W-1:0]  res_data_r;
    logic [DATA_W-1:0]  opa_s;
    logic [DATA_W-1:0]  opb_s;
    logic [DATA_W-1:0]  alu_y_s;
    logic               accept_s;
    logic               ready_s;

    // x0 always reads as zero, whatever the regfile holds there.
    assign opa_s    = (rs1_r == {REG_W{1'b0}}) ? {DATA_W{1'b0}} : rf_rv1;
    assign opb_s    = (rs2_r == {REG_W{1'b0}}) ? {DATA_W{1'b0}} : rf_rv2;
    assign accept_s = cmd_valid && ready_s;

    rf_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op_r),
        .a  (opa_r),
        .b  (opb_r),
        .y  (alu_y_s)
    );

    // State register; async reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and output decode, from state flops and latched rd only so
    // rf_we/res_valid are glitch-free and drop as soon as reset hits.
    always_comb begin
        state_nxt_s = state_r;
        ready_s     = 1'b0;
        rf_we       = 1'b0;
        res_valid   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
                if (cmd_valid) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: state_nxt_s = ST_EXEC;
            ST_EXEC: state_nxt_s = ST_WB;
            ST_WB: begin
                state_nxt_s = ST_IDLE;
                res_valid   = 1'b1;
                rf_we       = (rd_r != {REG_W{1'b0}});
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Command latch, operand capture in READ and result capture in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r       <= 3'd0;
            rs1_r      <= {REG_W{1'b0}};
            rs2_r      <= {REG_W{1'b0}};
            rd_r       <= {REG_W{1'b0}};
            opa_r      <= {DATA_W{1'b0}};
            opb_r      <= {DATA_W{1'b0}};
            res_data_r <= {DATA_W{1'b0}};
        end else begin
            if (accept_s) begin
                op_r  <= cmd_op;
                rs1_r <= cmd_rs1;
                rs2_r <= cmd_rs2;
                rd_r  <= cmd_rd;
            end
            if (state_r == ST_READ) begin
                opa_r <= opa_s;
                opb_r <= opb_s;
            end
            if (state_r == ST_EXEC) begin
                res_data_r <= alu_y_s;
            end
        end
    end

    assign cmd_ready = ready_s;
    assign rf_rs1    = rs1_r;
    assign rf_rs2    = rs2_r;
    assign rf_rd     = rd_r;
    assign rf_indata = res_data_r;
    assign res_data  = res_data_r;

endmodule
